// File: rtl/instruction_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, ALU select
// encodings, state codes and instruction-word field offsets.
package instruction_sequencer_pkg;

    // Instruction opcodes (3-bit field below the mode bit)
    localparam logic [2:0] OPC_STO  = 3'b000;
    localparam logic [2:0] OPC_ADD  = 3'b001;
    localparam logic [2:0] OPC_SUB  = 3'b010;
    localparam logic [2:0] OPC_AND  = 3'b011;
    localparam logic [2:0] OPC_OR   = 3'b100;
    localparam logic [2:0] OPC_XOR  = 3'b101;
    localparam logic [2:0] OPC_NOT  = 3'b110;
    localparam logic [2:0] OPC_HALT = 3'b111;

    // ALU select encodings seen by the external ALU
    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b110;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_XOR  = 3'b101;
    localparam logic [2:0] ALU_NOT  = 3'b111;

    // Sequencer state codes; codes 6 and 7 are unused and recover to IDLE
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_A   = 3'd1,
        ST_RD_B   = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALTED = 3'd5
    } state_e;

    // Total instruction width: mode + opcode + op1 + op2
    function automatic int instr_w(input int addr_w, input int data_w);
        return 4 + addr_w + data_w;
    endfunction

    // Bit position of the mode flag (MSB)
    function automatic int mode_bit(input int addr_w, input int data_w);
        return instr_w(addr_w, data_w) - 1;
    endfunction

    // LSB of the 3-bit opcode field
    function automatic int opc_lsb(input int addr_w, input int data_w);
        return instr_w(addr_w, data_w) - 4;
    endfunction

    // LSB of the op1 (destination address) field; op2 starts at bit 0
    function automatic int op1_lsb(input int data_w);
        return data_w;
    endfunction

endpackage

// File: rtl/instruction_sequencer_if.sv
// Bundle of the instruction handshake, RAM bus and ALU bus of the sequencer.
interface instruction_sequencer_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) ();
    import instruction_sequencer_pkg::*;

    localparam int INSTR_W = instr_w(ADDR_W, DATA_W);

    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic               instr_ready;
    logic [DATA_W-1:0]  mem_rdata;
    logic [DATA_W-1:0]  alu_result;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic               csn;
    logic               rwn;
    logic [2:0]         alu_sel;
    logic [DATA_W-1:0]  alu_a;
    logic [DATA_W-1:0]  alu_b;
    logic               alu_enable;
    logic               done;
    logic               halted;
    logic [2:0]         state;

    // Sequencer side
    modport master (
        input  instr_valid, instr, mem_rdata, alu_result,
        output instr_ready, mem_addr, mem_wdata, csn, rwn,
               alu_sel, alu_a, alu_b, alu_enable, done, halted, state
    );

    // Environment side: instruction source, RAM and ALU
    modport slave (
        output instr_valid, instr, mem_rdata, alu_result,
        input  instr_ready, mem_addr, mem_wdata, csn, rwn,
               alu_sel, alu_a, alu_b, alu_enable, done, halted, state
    );
endinterface

// File: rtl/instruction_sequencer_alu_sel_decode.sv
// Combinational opcode to ALU-select translation.
module alu_sel_decode
    import instruction_sequencer_pkg::*;
(
    input  logic [2:0] opcode,
    output logic [2:0] alu_sel
);

    // Map each arithmetic/logic opcode to the ALU's select encoding
    always_comb begin
        alu_sel = ALU_PASS;
        case (opcode)
            OPC_STO: alu_sel = ALU_PASS;
            OPC_ADD: alu_sel = ALU_ADD;
            OPC_SUB: alu_sel = ALU_SUB;
            OPC_AND: alu_sel = ALU_AND;
            OPC_OR:  alu_sel = ALU_OR;
            OPC_XOR: alu_sel = ALU_XOR;
            OPC_NOT: alu_sel = ALU_NOT;
            default: alu_sel = ALU_PASS; // HALT never reaches EXEC
        endcase
    end

endmodule

// File: rtl/instruction_sequencer.sv
// Multi-cycle instruction sequencer: fetches operands from RAM, drives an
// external ALU and writes the result back to the op1 address.
// DATA_W must be at least ADDR_W (op2 doubles as a RAM address in mode 1).
module instruction_sequencer
    import instruction_sequencer_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    instruction_sequencer_if.master bus
);

    localparam int INSTR_W  = instr_w(ADDR_W, DATA_W);
    localparam int MODE_BIT = mode_bit(ADDR_W, DATA_W);
    localparam int OPC_LSB  = opc_lsb(ADDR_W, DATA_W);
    localparam int OP1_LSB  = op1_lsb(DATA_W);

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic [DATA_W-1:0]  res_q, res_d;
    logic [2:0]         alu_sel_q, alu_sel_d;

    logic [2:0]         opcode_s;
    logic [2:0]         dec_sel_s;
    logic [ADDR_W-1:0]  op1_s;
    logic [ADDR_W-1:0]  op2_addr_s;

    assign opcode_s   = instr_q[OPC_LSB +: 3];
    assign op1_s      = instr_q[OP1_LSB +: ADDR_W];
    assign op2_addr_s = instr_q[ADDR_W-1:0];

    alu_sel_decode u_alu_sel_decode (
        .opcode  (opcode_s),
        .alu_sel (dec_sel_s)
    );

    // State and datapath registers; reset clears everything without a clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            instr_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            alu_sel_q <= ALU_PASS;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            alu_sel_q <= alu_sel_d;
        end
    end

    // Next-state and register-capture logic
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        alu_sel_d = alu_sel_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.instr_valid) begin
                    instr_d = bus.instr;
                    if (bus.instr[OPC_LSB +: 3] == OPC_HALT) begin
                        state_d = ST_HALTED;
                    end else begin
                        state_d = ST_RD_A;
                        // Immediate mode takes op2 straight into B
                        if (!bus.instr[MODE_BIT]) begin
                            b_d = bus.instr[DATA_W-1:0];
                        end else begin
                            b_d = b_q;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_A: begin
                a_d = bus.mem_rdata;
                if (instr_q[MODE_BIT]) begin
                    state_d = ST_RD_B;
                end else begin
                    state_d   = ST_EXEC;
                    alu_sel_d = dec_sel_s;
                end
            end
            ST_RD_B: begin
                b_d       = bus.mem_rdata;
                state_d   = ST_EXEC;
                alu_sel_d = dec_sel_s;
            end
            ST_EXEC: begin
                res_d   = bus.alu_result;
                state_d = ST_WB;
            end
            ST_WB:     state_d = ST_IDLE;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Moore output decode from the state register
    always_comb begin
        bus.instr_ready = 1'b0;
        bus.csn         = 1'b1;
        bus.rwn         = 1'b1;
        bus.alu_enable  = 1'b0;
        bus.done        = 1'b0;
        bus.halted      = 1'b0;
        bus.mem_addr    = '0;
        case (state_q)
            ST_IDLE: bus.instr_ready = 1'b1;
            ST_RD_A: begin
                bus.csn      = 1'b0;
                bus.mem_addr = op1_s;
            end
            ST_RD_B: begin
                bus.csn      = 1'b0;
                bus.mem_addr = op2_addr_s;
            end
            ST_EXEC: bus.alu_enable = 1'b1;
            ST_WB: begin
                bus.csn      = 1'b0;
                bus.rwn      = 1'b0;
                bus.done     = 1'b1;
                bus.mem_addr = op1_s;
            end
            ST_HALTED: bus.halted = 1'b1;
            default:   bus.csn    = 1'b1;
        endcase
    end

    assign bus.alu_sel   = alu_sel_q;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.mem_wdata = res_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed, table-driven bench for instruction_sequencer with a RAM model
// and a behavioural ALU stub.
module tb_instruction_sequencer;

    localparam int DW = 4;
    localparam int AW = 4;
    localparam int IW = 4 + AW + DW;

    logic clk = 1'b0;
    logic reset;

    instruction_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    instruction_sequencer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // RAM model with a bench-side preload port
    logic [DW-1:0] mem [16];
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (!bus.csn && !bus.rwn) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    assign bus.mem_rdata = mem[bus.mem_addr];

    function automatic logic [DW-1:0] alu_stub(input logic [2:0] s,
                                               input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
        case (s)
            3'b000:  return b;
            3'b001:  return a + b;
            3'b011:  return a - b;
            3'b110:  return a & b;
            3'b100:  return a | b;
            3'b101:  return a ^ b;
            3'b111:  return ~a;
            default: return '0;
        endcase
    endfunction

    assign bus.alu_result = alu_stub(bus.alu_sel, bus.alu_a, bus.alu_b);

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = v;
        @(posedge clk);
        @(negedge clk);
        pl_en   = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_state"},      32'(bus.state),       32'd0);
        chk({tag, "_csn"},        32'(bus.csn),         32'd1);
        chk({tag, "_rwn"},        32'(bus.rwn),         32'd1);
        chk({tag, "_alu_en"},     32'(bus.alu_enable),  32'd0);
        chk({tag, "_done"},       32'(bus.done),        32'd0);
        chk({tag, "_halted"},     32'(bus.halted),      32'd0);
        chk({tag, "_alu_sel"},    32'(bus.alu_sel),     32'd0);
        chk({tag, "_mem_addr"},   32'(bus.mem_addr),    32'd0);
        chk({tag, "_mem_wdata"},  32'(bus.mem_wdata),   32'd0);
        chk({tag, "_alu_a"},      32'(bus.alu_a),       32'd0);
        chk({tag, "_alu_b"},      32'(bus.alu_b),       32'd0);
        chk({tag, "_instr_ready"}, 32'(bus.instr_ready), 32'd1);
    endtask

    // Wait (bounded) at negedges until done; returns cycles waited and WB bus
    task automatic wait_done(output logic seen, output int cyc,
                             output logic [AW-1:0] waddr, output logic [DW-1:0] wdata);
        seen = 1'b0; cyc = 0; waddr = '0; wdata = '0;
        for (int c = 1; c <= 8 && !seen; c++) begin
            if (bus.done) begin
                seen  = 1'b1;
                cyc   = c;
                waddr = bus.mem_addr;
                wdata = bus.mem_wdata;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    // Offer one instruction from IDLE and follow it to the write-back cycle
    task automatic run_instr(input logic [IW-1:0] ins, output logic seen, output int lat,
                             output logic [2:0] sel, output logic [DW-1:0] a,
                             output logic [DW-1:0] b, output logic [AW-1:0] waddr,
                             output logic [DW-1:0] wdata, output logic wr_ok);
        bus.instr_valid = 1'b1;
        bus.instr       = ins;
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        seen = 1'b0; lat = 0; sel = '0; a = '0; b = '0;
        waddr = '0; wdata = '0; wr_ok = 1'b0;
        for (int c = 1; c <= 8 && !seen; c++) begin
            if (bus.state == 3'd3) begin
                sel = bus.alu_sel;
                a   = bus.alu_a;
                b   = bus.alu_b;
            end
            if (bus.done) begin
                seen  = 1'b1;
                lat   = c;
                waddr = bus.mem_addr;
                wdata = bus.mem_wdata;
                wr_ok = !bus.csn && !bus.rwn;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    typedef struct {
        logic [IW-1:0] instr;
        logic [AW-1:0] pa0;
        logic [DW-1:0] pv0;
        logic [AW-1:0] pa1;
        logic [DW-1:0] pv1;
        logic [2:0]    sel;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        int            lat;
    } vec_t;

    vec_t vecs [11];

    initial begin
        logic          seen, wr_ok, flag_csn, flag_halt, flag_rdy, flag_st, first_done;
        int            lat, low;
        logic [2:0]    sel;
        logic [DW-1:0] a, b, wdata;
        logic [AW-1:0] waddr;

        //          instr    pa0   pv0   pa1   pv1   sel     a     b     waddr wdata lat
        vecs[0]  = '{12'h135, 4'd3, 4'h4, 4'd3, 4'h4, 3'b001, 4'h4, 4'h5, 4'd3, 4'h9, 3};
        vecs[1]  = '{12'hA27, 4'd2, 4'h9, 4'd7, 4'h3, 3'b011, 4'h9, 4'h3, 4'd2, 4'h6, 4};
        vecs[2]  = '{12'h01A, 4'd1, 4'hC, 4'd1, 4'hC, 3'b000, 4'hC, 4'hA, 4'd1, 4'hA, 3};
        vecs[3]  = '{12'h11A, 4'd1, 4'hC, 4'd1, 4'hC, 3'b001, 4'hC, 4'hA, 4'd1, 4'h6, 3};
        vecs[4]  = '{12'h21A, 4'd1, 4'hC, 4'd1, 4'hC, 3'b011, 4'hC, 4'hA, 4'd1, 4'h2, 3};
        vecs[5]  = '{12'h31A, 4'd1, 4'hC, 4'd1, 4'hC, 3'b110, 4'hC, 4'hA, 4'd1, 4'h8, 3};
        vecs[6]  = '{12'h41A, 4'd1, 4'hC, 4'd1, 4'hC, 3'b100, 4'hC, 4'hA, 4'd1, 4'hE, 3};
        vecs[7]  = '{12'h51A, 4'd1, 4'hC, 4'd1, 4'hC, 3'b101, 4'hC, 4'hA, 4'd1, 4'h6, 3};
        vecs[8]  = '{12'h61A, 4'd1, 4'hC, 4'd1, 4'hC, 3'b111, 4'hC, 4'hA, 4'd1, 4'h3, 3};
        vecs[9]  = '{12'h933, 4'd3, 4'h5, 4'd3, 4'h5, 3'b001, 4'h5, 4'h5, 4'd3, 4'hA, 4};
        vecs[10] = '{12'hD45, 4'd4, 4'h9, 4'd5, 4'h3, 3'b101, 4'h9, 4'h3, 4'd4, 4'hA, 4};

        // Reset: outputs must be at reset values while reset is held
        reset = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr = '0;
        pl_en = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        @(negedge clk);
        @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;
        @(negedge clk);

        // Table-driven single instructions
        for (int i = 0; i < 11; i++) begin
            preload(vecs[i].pa0, vecs[i].pv0);
            preload(vecs[i].pa1, vecs[i].pv1);
            run_instr(vecs[i].instr, seen, lat, sel, a, b, waddr, wdata, wr_ok);
            chk($sformatf("v%0d_done_seen", i), 32'(seen),  32'd1);
            chk($sformatf("v%0d_latency", i),   32'(lat),   32'(vecs[i].lat));
            chk($sformatf("v%0d_alu_sel", i),   32'(sel),   32'(vecs[i].sel));
            chk($sformatf("v%0d_alu_a", i),     32'(a),     32'(vecs[i].a));
            chk($sformatf("v%0d_alu_b", i),     32'(b),     32'(vecs[i].b));
            chk($sformatf("v%0d_wb_addr", i),   32'(waddr), 32'(vecs[i].waddr));
            chk($sformatf("v%0d_wb_data", i),   32'(wdata), 32'(vecs[i].wdata));
            chk($sformatf("v%0d_wb_strobe", i), 32'(wr_ok), 32'd1);
            @(negedge clk);
            chk($sformatf("v%0d_ram", i),       32'(mem[vecs[i].waddr]), 32'(vecs[i].wdata));
            chk($sformatf("v%0d_idle", i),      32'(bus.state), 32'd0);
        end

        // Back-to-back: valid held high, second instruction waits for IDLE
        preload(4'd3, 4'h4);
        preload(4'd4, 4'h5);
        bus.instr_valid = 1'b1;
        bus.instr = 12'h135;
        @(posedge clk);
        @(negedge clk);
        bus.instr = 12'h640;
        low = 0;
        first_done = 1'b0;
        while (!bus.instr_ready && low < 10) begin
            if (bus.done) begin
                first_done = 1'b1;
                chk("b2b_first_addr", 32'(bus.mem_addr),  32'd3);
                chk("b2b_first_data", 32'(bus.mem_wdata), 32'h9);
            end
            low++;
            @(negedge clk);
        end
        chk("b2b_first_done", 32'(first_done), 32'd1);
        chk("b2b_ready_low",  32'(low),        32'd3);
        chk("b2b_idle",       32'(bus.state),  32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        chk("b2b_second_rd_a",  32'(bus.state),    32'd1);
        chk("b2b_second_raddr", 32'(bus.mem_addr), 32'd4);
        wait_done(seen, lat, waddr, wdata);
        chk("b2b_second_done", 32'(seen),  32'd1);
        chk("b2b_second_addr", 32'(waddr), 32'd4);
        chk("b2b_second_data", 32'(wdata), 32'hA);
        @(negedge clk);

        // HALT: no RAM access, halted sticks, further valid ignored
        bus.instr_valid = 1'b1;
        bus.instr = 12'h700;
        @(posedge clk);
        @(negedge clk);
        bus.instr = 12'h135;
        flag_csn = 1'b0; flag_halt = 1'b0; flag_rdy = 1'b0; flag_st = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (!bus.csn)          flag_csn  = 1'b1;
            if (!bus.halted)       flag_halt = 1'b1;
            if (bus.instr_ready)   flag_rdy  = 1'b1;
            if (bus.state != 3'd5) flag_st   = 1'b1;
            @(negedge clk);
        end
        chk("halt_csn_low_seen",    32'(flag_csn),  32'd0);
        chk("halt_halted_dropped",  32'(flag_halt), 32'd0);
        chk("halt_ready_seen",      32'(flag_rdy),  32'd0);
        chk("halt_state_left",      32'(flag_st),   32'd0);
        bus.instr_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("halt_reset_halted", 32'(bus.halted), 32'd0);
        chk("halt_reset_state",  32'(bus.state),  32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset during write-back aborts the write immediately
        preload(4'd3, 4'h4);
        bus.instr_valid = 1'b1;
        bus.instr = 12'h135;
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        wait_done(seen, lat, waddr, wdata);
        chk("wbrst_reached_wb", 32'(seen), 32'd1);
        reset = 1'b1;
        #1;
        check_reset_values("wbrst");
        @(posedge clk);
        @(negedge clk);
        chk("wbrst_no_write", 32'(mem[3]), 32'h4);

        // First accept on the first edge after reset release
        reset = 1'b0;
        bus.instr_valid = 1'b1;
        bus.instr = 12'h135;
        chk("release_ready", 32'(bus.instr_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        chk("release_rd_a",  32'(bus.state),    32'd1);
        chk("release_raddr", 32'(bus.mem_addr), 32'd3);
        wait_done(seen, lat, waddr, wdata);
        chk("release_done", 32'(seen),  32'd1);
        chk("release_data", 32'(wdata), 32'h9);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 Parameter DATA_W, default 4, data/operand width; SHALL satisfy DATA_W >= ADDR_W.
REQ-002 Parameter ADDR_W, default 4, RAM address width.
REQ-003 Derived constant INSTR_W = 4 + ADDR_W + DATA_W; layout [INSTR_W-1] mode, next 3 bits opcode, next ADDR_W bits op1 (destination address), low DATA_W bits op2.
REQ-004 Clocking: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 instr_valid  in  1  instruction offered.
REQ-008 instr  in  INSTR_W  instruction word.
REQ-009 instr_ready  out  1  sequencer accepts an instruction this cycle.
REQ-010 mem_rdata  in  DATA_W  RAM read data, combinational (same cycle as address/csn).
REQ-011 alu_result  in  DATA_W  ALU output, combinational from alu_a/alu_b/alu_sel.
REQ-012 mem_addr  out  ADDR_W;  mem_wdata  out  DATA_W;  csn  out  1 (active-low select);  rwn  out  1 (1 read, 0 write).
REQ-013 alu_sel  out  3;  alu_a  out  DATA_W;  alu_b  out  DATA_W;  alu_enable  out  1.
REQ-014 done  out  1  one-cycle pulse in write-back cycle;  halted  out  1;  state  out  3  current state code.

Function
REQ-015 States: IDLE, RD_A, RD_B, EXEC, WB, HALTED; all outputs except alu_a/alu_b/mem_wdata SHALL decode from state register only (Moore).
REQ-016 IDLE: instr_ready=1, csn=1, rwn=1, alu_enable=0; on instr_valid&&instr_ready latch instr; opcode 111 -> HALTED, else -> RD_A.
REQ-017 Mode 0 (immediate): b_reg <= op2 at accept; RD_A -> EXEC.
REQ-018 Mode 1 (memory source): RD_A -> RD_B; RD_B drives mem_addr=op2[ADDR_W-1:0], csn=0, rwn=1, captures b_reg <= mem_rdata at cycle end.
REQ-019 RD_A: mem_addr=op1, csn=0, rwn=1; captures a_reg <= mem_rdata at cycle end.
REQ-020 EXEC: csn=1, alu_enable=1, alu_a=a_reg, alu_b=b_reg, alu_sel per REQ-021; captures res_reg <= alu_result at cycle end; -> WB.
REQ-021 alu_sel map: 000 STO->000, 001 ADD->001, 010 SUB->011, 011 AND->110, 100 OR->100, 101 XOR->101, 110 NOT->111; alu_sel holds last value outside EXEC.
REQ-022 WB: mem_addr=op1, mem_wdata=res_reg, csn=0, rwn=0, done=1; -> IDLE.
REQ-023 Latency: done asserted 3 cycles after accept edge (mode 0), 4 cycles (mode 1); throughput one instruction per 4/5 cycles including IDLE.
REQ-024 instr_ready=0 in every state except IDLE; instr_valid outside IDLE SHALL be ignored, no latch change.
REQ-025 HALTED: halted=1, instr_ready=0, csn=1, alu_enable=0; exit only by reset.
REQ-026 op1 == op2 address in mode 1 SHALL be legal (read same location twice).
REQ-027 Unused state codes SHALL transition to IDLE next cycle with csn=1.

Reset
REQ-028 On reset assertion, immediately (no clock): state=IDLE, csn=1, rwn=1, alu_enable=0, done=0, halted=0, alu_sel=000, mem_addr=0, mem_wdata=0, a_reg=b_reg=res_reg=0.
REQ-029 Reset asserted during WB SHALL abort the write (csn returns 1 asynchronously); in-flight instruction discarded.
REQ-030 First accept possible on first rising clk edge after reset deassertion (instr_ready=1 throughout reset-release cycle).

Structure
REQ-031 Shared package SHALL hold opcode constants, alu_sel encodings, state encoding, and INSTR_W field-offset functions.
REQ-032 One combinational sub-module alu_sel_decode (opcode -> alu_sel); FSM and datapath registers in instruction_sequencer.

Verification
REQ-033 Mode 0 ADD: mem[3]=4, instr=0x135 -> EXEC alu_a=4, alu_b=5, alu_sel=001; stub ALU 9 -> WB writes addr 3, data 9, done 3 cycles after accept.
REQ-034 Mode 1 SUB: mem[2]=9, mem[7]=3, instr=0xA27 -> RD_A addr 2, RD_B addr 7, alu_sel=011, WB writes 6 to addr 2, done 4 cycles after accept.
REQ-035 Back-to-back valid held high with 0x135 then 0x640 -> second accepted only in IDLE after first done; instr_ready low 3 cycles between.
REQ-036 HALT instr=0x700 -> no csn low, halted=1 indefinitely; valid ignored; reset clears halted.
REQ-037 Reset asserted mid-WB of 0x135 -> csn=1 same cycle, no write to addr 3, state=IDLE, all outputs at reset values.
REQ-038 Sweep opcodes 000-110 in mode 0 -> alu_sel matches REQ-021 map exactly.
